// File: rtl/interpol_3_frac_search_if.sv
// ----------------------------------------------------------------------------
// interpol_3_frac_search_if
//
// Call/return channel between the fractional-lag search sequencer and the
// shared Interpol_3 unit.
//
//   interp_start   master -> slave  one-cycle start pulse for one interpolation
//   interp_x       master -> slave  address of x[0] in scratch memory
//   interp_frac    master -> slave  signed fraction, stable from pulse to done
//   interp_done    slave  -> master done indication (pulse or held level)
//   interp_result  slave  -> master signed Q15 result, valid while done is high
//
// Modports:
//   master  the search sequencer (drives start/x/frac)
//   slave   the Interpol_3 unit (drives done/result)
// ----------------------------------------------------------------------------
interface interpol_3_frac_search_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
);

    logic              interp_start;
    logic [ADDR_W-1:0] interp_x;
    logic [DATA_W-1:0] interp_frac;
    logic              interp_done;
    logic [DATA_W-1:0] interp_result;

    modport master (
        output interp_start,
        output interp_x,
        output interp_frac,
        input  interp_done,
        input  interp_result
    );

    modport slave (
        input  interp_start,
        input  interp_x,
        input  interp_frac,
        output interp_done,
        output interp_result
    );

endinterface

// File: rtl/interpol_3_frac_search.sv
// ----------------------------------------------------------------------------
// interpol_3_frac_search
//
// Walks a signed, inclusive range of fractional lags [frac_min, frac_max] at a
// fixed integer lag address, issuing one call to a shared Interpol_3 unit per
// fraction and keeping the largest signed result. Ties keep the lowest
// fraction. An empty range (frac_min > frac_max) finishes without any call and
// flags err, reporting best_frac = frac_min and best_val = most negative value.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous reset, active low
//   start          one-cycle request, only sampled while idle
//   x_addr         x[0] address, latched on start and forwarded to Interpol_3
//   frac_min       signed first fraction, latched on start
//   frac_max       signed last fraction (inclusive), latched on start
//   busy           high from the cycle after an accepted start until done
//   done           one-cycle completion pulse (busy is already low)
//   err            with done: empty range, no Interpol_3 calls were made
//   best_frac      fraction with the maximum result (held after done)
//   best_val       maximum signed result (held after done)
//   interp         master side of the Interpol_3 call channel
// ----------------------------------------------------------------------------
module interpol_3_frac_search #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [ADDR_W-1:0]               x_addr,
    input  logic [DATA_W-1:0]               frac_min,
    input  logic [DATA_W-1:0]               frac_max,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [DATA_W-1:0]               best_frac,
    output logic [DATA_W-1:0]               best_val,
    interpol_3_frac_search_if.master        interp
);

    // Most negative DATA_W value, reported as best_val for an empty range.
    localparam logic [DATA_W-1:0] MinVal = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] One    = {{(DATA_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StIssue,
        StWait,
        StCmp,
        StFin
    } state_e;

    state_e            state_q, state_d;

    logic [ADDR_W-1:0] x_q, x_d;             // x address for the whole search
    logic [DATA_W-1:0] fmax_q, fmax_d;       // last fraction (inclusive)
    logic [DATA_W-1:0] cur_q, cur_d;         // fraction currently being evaluated
    logic [DATA_W-1:0] res_q, res_d;         // accepted Interpol_3 result
    logic [DATA_W-1:0] best_frac_q, best_frac_d;
    logic [DATA_W-1:0] best_val_q, best_val_d;
    logic [DATA_W-1:0] ifrac_q, ifrac_d;     // fraction presented to Interpol_3
    logic              istart_q, istart_d;
    logic              first_q, first_d;     // no result compared yet
    logic              seen_low_q, seen_low_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            x_q         <= '0;
            fmax_q      <= '0;
            cur_q       <= '0;
            res_q       <= '0;
            best_frac_q <= '0;
            best_val_q  <= '0;
            ifrac_q     <= '0;
            istart_q    <= 1'b0;
            first_q     <= 1'b0;
            seen_low_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            fmax_q      <= fmax_d;
            cur_q       <= cur_d;
            res_q       <= res_d;
            best_frac_q <= best_frac_d;
            best_val_q  <= best_val_d;
            ifrac_q     <= ifrac_d;
            istart_q    <= istart_d;
            first_q     <= first_d;
            seen_low_q  <= seen_low_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        fmax_d      = fmax_q;
        cur_d       = cur_q;
        res_d       = res_q;
        best_frac_d = best_frac_q;
        best_val_d  = best_val_q;
        ifrac_d     = ifrac_q;
        istart_d    = 1'b0;
        first_d     = first_q;
        seen_low_d  = seen_low_q;
        done_d      = 1'b0;
        err_d       = err_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    x_d     = x_addr;
                    fmax_d  = frac_max;
                    cur_d   = frac_min;
                    first_d = 1'b1;
                    err_d   = 1'b0;
                    state_d = StCheck;
                end
            end

            StCheck: begin
                // cur still holds frac_min here.
                if ($signed(cur_q) > $signed(fmax_q)) begin
                    err_d       = 1'b1;
                    best_frac_d = cur_q;
                    best_val_d  = MinVal;
                    state_d     = StFin;
                end else begin
                    state_d = StIssue;
                end
            end

            StIssue: begin
                // Start and fraction are registered, so both appear together
                // in the first WAIT cycle.
                istart_d   = 1'b1;
                ifrac_d    = cur_q;
                seen_low_d = 1'b0;
                state_d    = StWait;
            end

            StWait: begin
                // A done level left high by the previous call must drop once
                // before a new done is believed.
                if (interp.interp_done && seen_low_q) begin
                    res_d   = interp.interp_result;
                    state_d = StCmp;
                end else if (!interp.interp_done) begin
                    seen_low_d = 1'b1;
                end
            end

            StCmp: begin
                // Strict compare: equal results keep the earlier fraction.
                if (first_q || ($signed(res_q) > $signed(best_val_q))) begin
                    best_val_d  = res_q;
                    best_frac_d = cur_q;
                end
                first_d = 1'b0;
                // Stop on equality so frac_max = max positive never wraps cur.
                if (cur_q == fmax_q) begin
                    state_d = StFin;
                end else begin
                    cur_d   = cur_q + One;
                    state_d = StIssue;
                end
            end

            StFin: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // done_q rises as the FSM returns to idle, so busy is already low with it.
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign err       = err_q;
    assign best_frac = best_frac_q;
    assign best_val  = best_val_q;

    assign interp.interp_start = istart_q;
    assign interp.interp_x     = x_q;
    assign interp.interp_frac  = ifrac_q;

endmodule
